// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared fetch-stage types, constants and instruction field positions. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// +----------------------------------------------------------------------+
// | pc_reg                                                               |
// | Program counter with load (redirect) and increment; load wins.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= load_pc;
        end else if (inc) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +----------------------------------------------------------------------+
// | instr_fetch_unit                                                     |
// | Fetches instruction words over req/ack and presents decoded fields.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] target,
    output logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t r_state;
    logic         r_req;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc_plus4;
    logic [31:0]  r_count;
    logic [31:0]  r_pending;

    logic [31:0]  w_pc;
    logic [31:0]  w_redirect_pc;
    logic         w_load;
    logic [31:0]  w_load_pc;
    logic         w_inc;

    assign w_redirect_pc = align_pc(redirect_pc);

    // PC update: a redirect always beats the sequential increment.
    always_comb begin
        w_load    = 1'b0;
        w_load_pc = w_redirect_pc;
        w_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = redirect_valid;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_load = redirect_valid;
                    w_inc  = !redirect_valid;
                end
            end
            ST_FLUSH: begin
                if (imem_ack) begin
                    w_load    = 1'b1;
                    w_load_pc = redirect_valid ? w_redirect_pc : r_pending;
                end
            end
            ST_HOLD: begin
                w_load = redirect_valid;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .load_pc (w_load_pc),
        .inc     (w_inc),
        .pc      (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_count    <= 32'd0;
            r_pending  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (!redirect_valid) begin
                            r_instr    <= imem_rdata;
                            r_pc_plus4 <= w_pc + PC_STEP;
                            r_state    <= ST_HOLD;
                            r_req      <= 1'b0;
                            r_valid    <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        // The outstanding access must still complete at the old address.
                        r_pending <= w_redirect_pc;
                        r_state   <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (imem_ack) begin
                        r_state <= ST_FETCH;
                    end else if (redirect_valid) begin
                        r_pending <= w_redirect_pc;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        r_count <= r_count + 32'd1;
                    end
                    if (instr_ready || redirect_valid) begin
                        r_valid <= 1'b0;
                        r_req   <= enable;
                        r_state <= enable ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = w_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[OPC_MSB:OPC_LSB];
    assign rs          = r_instr[RS_MSB:RS_LSB];
    assign rt          = r_instr[RT_MSB:RT_LSB];
    assign rd          = r_instr[RD_MSB:RD_LSB];
    assign imm         = r_instr[IMM_MSB:IMM_LSB];
    assign target      = r_instr[TARGET_MSB:TARGET_LSB];
    assign pc_plus4    = r_pc_plus4;
    assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_instr_fetch_unit                                                  |
// | Directed and random stimulus against a transaction-level model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;

    logic        en2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [5:0]  opcode2;
    logic [4:0]  rs2, rt2, rd2;
    logic [15:0] imm2;
    logic [25:0] target2;
    logic [31:0] pc_plus42;
    logic [31:0] fetch_count2;
    logic        ack2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(rst), .enable(en),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(ack), .imem_rdata(rdata),
        .instr_valid(instr_valid), .instr_ready(rdy),
        .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target), .pc_plus4(pc_plus4),
        .redirect_valid(rv), .redirect_pc(rpc), .fetch_count(fetch_count)
    );

    // Second instance starting at the top of the address space, zero-wait memory.
    assign ack2 = imem_req2;

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(rst), .enable(en2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(ack2), .imem_rdata(32'h1234_5678),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .instr(instr2), .opcode(opcode2), .rs(rs2), .rt(rt2), .rd(rd2),
        .imm(imm2), .target(target2), .pc_plus4(pc_plus42),
        .redirect_valid(1'b0), .redirect_pc(32'd0), .fetch_count(fetch_count2)
    );

    // Reference model: one outstanding memory transaction, maybe doomed,
    // and at most one instruction on offer to the consumer.
    logic        m_req;
    logic        m_doomed;
    logic [31:0] m_pend;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic [31:0] m_count;

    int  ws = 0;
    int  wcnt = 0;
    logic force_ack = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2001_0005;
        if (a == 32'd4) return 32'h0000_0000;
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    task automatic model_reset();
        m_req = 0; m_doomed = 0; m_pend = 0; m_valid = 0;
        m_pc = 32'd0; m_instr = 0; m_pp4 = 0; m_count = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (rst) begin
            model_reset();
        end else if (m_valid) begin
            if (rdy) m_count = m_count + 1;
            if (rv) m_pc = tgt;
            if (rv || rdy) begin
                m_valid = 0;
                m_req = en;
            end
        end else if (m_req && !m_doomed) begin
            if (ack) begin
                if (rv) m_pc = tgt;
                else begin
                    m_instr = rdata;
                    m_pp4 = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4;
                    m_valid = 1;
                    m_req = 0;
                end
            end else if (rv) begin
                m_pend = tgt;
                m_doomed = 1;
            end
        end else if (m_req) begin
            if (ack) begin
                m_pc = rv ? tgt : m_pend;
                m_doomed = 0;
            end else if (rv) begin
                m_pend = tgt;
            end
        end else begin
            if (rv) m_pc = tgt;
            if (en) m_req = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("instr", instr, m_instr);
        chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
        chk("rs", {27'd0, rs}, {27'd0, m_instr[25:21]});
        chk("rt", {27'd0, rt}, {27'd0, m_instr[20:16]});
        chk("rd", {27'd0, rd}, {27'd0, m_instr[15:11]});
        chk("imm", {16'd0, imm}, {16'd0, m_instr[15:0]});
        chk("target", {6'd0, target}, {6'd0, m_instr[25:0]});
        chk("pc_plus4", pc_plus4, m_pp4);
        chk("fetch_count", fetch_count, m_count);
    endtask

    // Check current outputs, apply this cycle's inputs, advance one clock.
    task automatic tick();
        logic req_before;
        check_outputs();
        req_before = m_req;
        ack   = force_ack ? 1'b1 : (m_req && (wcnt >= ws));
        rdata = mem_word(m_pc);
        model_step();
        if (rst || !req_before || ack) wcnt = 0;
        else wcnt = wcnt + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; en = 0; ack = 0; rdata = 0; rdy = 0; rv = 0; rpc = 0; en2 = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 0;
        tick();
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_count", fetch_count, 32'd0);
        chk("wrap_reset_addr", imem_addr2, 32'hFFFF_FFFC);

        // Wrap-around instance
        en2 = 1;
        tick();
        tick();
        chk("wrap_valid", {31'd0, instr_valid2}, 32'd1);
        chk("wrap_pc_plus4", pc_plus42, 32'd0);
        chk("wrap_instr", instr2, 32'h1234_5678);
        tick();
        chk("wrap_next_addr", imem_addr2, 32'd0);
        chk("wrap_next_req", {31'd0, imem_req2}, 32'd1);
        en2 = 0;

        // Sequential zero-wait fetch
        en = 1; rdy = 1; ws = 0;
        tick();
        tick();
        chk("seq_valid", {31'd0, instr_valid}, 32'd1);
        chk("seq_opcode", {26'd0, opcode}, 32'h08);
        chk("seq_rs", {27'd0, rs}, 32'd0);
        chk("seq_rt", {27'd0, rt}, 32'd1);
        chk("seq_imm", {16'd0, imm}, 32'd5);
        chk("seq_pc_plus4", pc_plus4, 32'd4);
        tick();
        tick();
        tick();
        chk("seq_count", fetch_count, 32'd2);
        chk("seq_addr", imem_addr, 32'd8);

        // Backpressure
        rdy = 0;
        tick();
        repeat (5) tick();
        chk("bp_valid", {31'd0, instr_valid}, 32'd1);
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_instr", instr, mem_word(32'd8));
        rdy = 1;
        tick();
        chk("bp_next_addr", imem_addr, 32'd12);

        // Redirect during a slow fetch goes through FLUSH
        ws = 3; rv = 1; rpc = 32'h0000_0043;
        tick();
        rv = 0;
        tick();
        tick();
        chk("flush_addr_held", imem_addr, 32'd12);
        chk("flush_no_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("flush_new_addr", imem_addr, 32'h40);
        chk("flush_req", {31'd0, imem_req}, 32'd1);

        // Redirect coinciding with ack
        ws = 0; rv = 1; rpc = 32'h0000_0100;
        tick();
        rv = 0;
        chk("same_cycle_addr", imem_addr, 32'h100);
        chk("same_cycle_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("same_cycle_pp4", pc_plus4, 32'h104);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom % 8) != 0;
            rdy = ($urandom % 3) != 0;
            rv  = ($urandom % 10) == 0;
            rpc = $urandom;
            rst = ($urandom % 100) == 0;
            if (($urandom % 16) == 0) ws = $urandom_range(0, 3);
            tick();
        end
        rst = 0; rv = 0;

        // Reset in FLUSH, then a late ack while idle
        rst = 1;
        tick();
        rst = 0; en = 1; ws = 3; rdy = 1;
        tick();
        rv = 1; rpc = 32'h0000_0200;
        tick();
        rv = 0; rst = 1;
        tick();
        rst = 0; en = 0; force_ack = 1;
        tick();
        force_ack = 0;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_count", fetch_count, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        chk("midrst_instr", instr, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
